// File: rtl/datapath_pkg.sv
// Shared constants and types for the datapath sequencer: opcodes, FSM states,
// register-file write-select codes and instruction classes.
package datapath_pkg;

  localparam int TIMEOUT_DEF = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_DIV  = 4'h9;
  localparam logic [3:0] OP_SWAP = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] WDST_R1    = 2'b00;
  localparam logic [1:0] WDST_R1R2  = 2'b01;
  localparam logic [1:0] WDST_R1R15 = 2'b10;
  localparam logic [1:0] WDST_NONE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_SINGLE, CLS_MULTI, CLS_SWAP, CLS_HALT, CLS_ILLEGAL
  } cls_e;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: instruction class, write-select code and
// illegal flag.
module instr_class_decode
  import datapath_pkg::*;
(
  input  logic [3:0] opcode,
  output cls_e       cls,
  output logic [1:0] wdst,
  output logic       illegal
);

  always_comb begin
    cls  = CLS_ILLEGAL;
    wdst = WDST_NONE;
    case (opcode)
      OP_NOP: cls = CLS_NOP;
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        cls  = CLS_SINGLE;
        wdst = WDST_R1;
      end
      OP_MUL, OP_DIV: begin
        cls  = CLS_MULTI;
        wdst = WDST_R1R15;
      end
      OP_SWAP: begin
        cls  = CLS_SWAP;
        wdst = WDST_R1R2;
      end
      OP_HALT: cls = CLS_HALT;
      default: ;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/datapath_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving a register file and a
// multi-cycle ALU, with EXEC timeout and a terminal HALT state.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int PC_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      read_add1,
  output logic [3:0]      read_add2,
  output logic [1:0]      write_dst,
  output logic [3:0]      alu_op,
  output logic            alu_start,
  input  logic            alu_done,
  output logic            halted,
  output logic            err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [15:0]       ir_q;
  logic [PC_W-1:0]   pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        write_dst_q;
  logic              alu_start_q, instr_ready_q, halted_q, err_q;

  logic              fetch_acc;
  logic [3:0]        dec_op;
  cls_e              dec_cls;
  logic [1:0]        dec_wdst;
  logic              dec_illegal;
  logic              unused_funct;

  // Classify the incoming word on the accepting FETCH edge so alu_start and
  // the illegal-opcode err can be registered into the DECODE cycle.
  assign fetch_acc = (state_q == S_FETCH) && instr_valid;
  assign dec_op    = fetch_acc ? instr[15:12] : ir_q[15:12];

  instr_class_decode u_dec (
    .opcode  (dec_op),
    .cls     (dec_cls),
    .wdst    (dec_wdst),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ir_q          <= '0;
      pc_q          <= '0;
      cnt_q         <= '0;
      write_dst_q   <= WDST_NONE;
      alu_start_q   <= 1'b0;
      instr_ready_q <= 1'b0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      alu_start_q <= 1'b0;
      err_q       <= 1'b0;
      write_dst_q <= WDST_NONE;
      case (state_q)
        S_IDLE: if (start) begin
          state_q       <= S_FETCH;
          instr_ready_q <= 1'b1;
        end
        S_FETCH: if (instr_valid) begin
          ir_q          <= instr;
          pc_q          <= pc_q + PC_W'(1);
          state_q       <= S_DECODE;
          instr_ready_q <= 1'b0;
          alu_start_q   <= (dec_cls == CLS_MULTI);
          err_q         <= dec_illegal;
        end
        S_DECODE: case (dec_cls)
          CLS_SINGLE, CLS_SWAP: begin
            state_q     <= S_WB;
            write_dst_q <= dec_wdst;
          end
          CLS_MULTI: begin
            state_q <= S_EXEC;
            cnt_q   <= '0;
          end
          CLS_HALT: begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
          default: begin
            state_q       <= S_FETCH;
            instr_ready_q <= 1'b1;
          end
        endcase
        // alu_done is tested first so a result on the last allowed cycle wins.
        S_EXEC: if (alu_done) begin
          state_q     <= S_WB;
          write_dst_q <= dec_wdst;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_q       <= S_FETCH;
          instr_ready_q <= 1'b1;
          err_q         <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_WB: begin
          state_q       <= S_FETCH;
          instr_ready_q <= 1'b1;
        end
        S_HALT: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready  = instr_ready_q;
  assign pc           = pc_q;
  assign read_add1    = ir_q[11:8];
  assign read_add2    = ir_q[7:4];
  assign write_dst    = write_dst_q;
  assign alu_op       = ir_q[15:12];
  assign alu_start    = alu_start_q;
  assign halted       = halted_q;
  assign err          = err_q;
  assign unused_funct = ^ir_q[3:0];

endmodule
